// File: rtl/mux_sync_pkg.sv
// Shared types and helpers for the mux_sync transmit-side arbiter.
package mux_sync_pkg;

  localparam int MAX_REQ = 16;
  localparam int PTR_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot pick of the first valid bit at or after ptr, wrapping modulo n.
  // Walks offsets high-to-low so the smallest offset is the last to write.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] gnt;
    int                 idx;
    gnt = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (valid[idx]) gnt = MAX_REQ'(1) << idx;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer for the destination ack level; clears to 0 on reset.
module cdc_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) ff <= '0;
    else         ff <= {ff[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = ff[SYNC_STAGES-1];

endmodule

// File: rtl/mux_sync_tx_arbiter.sv
// Round-robin front end sharing one mux_sync CDC channel; holds the winning
// word/ID stable and runs a 4-phase req/ack handshake with the destination.
module mux_sync_tx_arbiter
  import mux_sync_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int SYNC_STAGES = 2,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [ID_W-1:0]               src_id_o,
  output logic                          sync_ctrl_o,
  input  logic                          ack_i,
  output logic                          busy_o,
  output logic                          timeout_o
);

  state_e                               state;
  logic                                 ack_s;
  logic [ID_W-1:0]                      rr_ptr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_words;
  logic [MAX_REQ-1:0]                   pick;
  logic [NUM_REQ-1:0]                   gnt;
  logic [ID_W-1:0]                      gnt_id;
  logic [ID_W-1:0]                      next_ptr;
  logic                                 accept;
  logic                                 unused_pick;

  cdc_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .async_i(ack_i),
    .sync_o (ack_s)
  );

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_words[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign pick        = rr_pick(MAX_REQ'(req_valid_i), PTR_W'(rr_ptr), NUM_REQ);
  assign unused_pick = ^pick;

  // A still-high ack_s means the destination has not finished the previous
  // 4-phase cycle (e.g. a transfer cut short by reset), so hold off grants.
  always_comb begin
    gnt = '0;
    if (rstn_i && state == IDLE && !ack_s) gnt = pick[NUM_REQ-1:0];
  end

  always_comb begin
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (pick[k]) gnt_id = ID_W'(k);
  end

  assign next_ptr    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  assign req_ready_o = gnt;
  assign accept      = |(gnt & req_valid_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      data_o      <= '0;
      src_id_o    <= '0;
      sync_ctrl_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= REQ_HI;
            data_o      <= req_words[gnt_id];
            src_id_o    <= gnt_id;
            rr_ptr      <= next_ptr;
            sync_ctrl_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            state       <= REQ_LO;
            sync_ctrl_o <= 1'b0;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          sync_ctrl_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog only flags a stuck handshake; the FSM keeps waiting regardless.
  if (TIMEOUT_CYC > 0) begin : g_timeout
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        cnt       <= '0;
        timeout_o <= 1'b0;
      end else if (accept) begin
        cnt <= '0;
      end else if (state != IDLE && cnt != CNT_W'(TIMEOUT_CYC)) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(TIMEOUT_CYC - 1)) timeout_o <= 1'b1;
      end
    end
  end else begin : g_no_timeout
    always_ff @(posedge clk_i) begin
      timeout_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sync_tx_arbiter.sv
// Scoreboard bench for mux_sync_tx_arbiter: stimulus queues expected words,
// a negedge monitor checks each transfer as sync_ctrl_o rises.
module tb_mux_sync_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int SS = 3;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    data;
  logic [1:0]       src_id;
  logic             sync_ctrl;
  logic             ack;
  logic             busy;
  logic             timeout;
  logic             ack_force_en = 1'b1;
  logic             ack_force_val = 1'b0;

  // Ideal destination: ack follows req in the same cycle unless forced.
  assign ack = ack_force_en ? ack_force_val : sync_ctrl;

  always #5 clk = ~clk;

  mux_sync_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .data_o     (data),
    .src_id_o   (src_id),
    .sync_ctrl_o(sync_ctrl),
    .ack_i      (ack),
    .busy_o     (busy),
    .timeout_o  (timeout)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int max, output int cyc);
    cyc = 0;
    while (busy && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy_o still 1 after %0d cycles, expected 0", name, max);
    end
  endtask

  task automatic set_word(input int k, input logic [DW-1:0] w);
    req_data[k*DW +: DW] = w;
  endtask

  // Monitor: one scoreboard pop per rising sync_ctrl_o, plus hold checking.
  initial begin
    logic          prev_sync;
    logic          prev_busy;
    logic          stab_bad;
    logic [DW-1:0] prev_data;
    logic [33:0]   e;
    prev_sync = 1'b0;
    prev_busy = 1'b0;
    stab_bad  = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (sync_ctrl && !prev_sync) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL xfer_unexpected: got id %0d data 0x%h, expected no transfer", src_id, data);
        end else begin
          e = exp_q.pop_front();
          check("xfer_id", 64'(src_id), 64'(e[33:32]));
          check("xfer_data", 64'(data), 64'(e[31:0]));
        end
        n_xfer++;
      end
      if (busy && prev_busy && data !== prev_data) stab_bad = 1'b1;
      if (!busy && prev_busy) begin
        check("data_stable_while_busy", 64'(stab_bad), 64'(0));
        stab_bad = 1'b0;
      end
      prev_sync = sync_ctrl;
      prev_busy = busy;
      prev_data = data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int base;
    int t;

    // Reset state, with all requesters valid to prove ready stays low.
    rstn = 1'b0;
    ack_force_en = 1'b1;
    ack_force_val = 1'b0;
    for (int k = 0; k < NR; k++) set_word(k, 32'hC0DE_0000 + k);
    req_valid = '1;
    repeat (3) @(negedge clk);
    check("rst_data", 64'(data), 64'(0));
    check("rst_src_id", 64'(src_id), 64'(0));
    check("rst_sync", 64'(sync_ctrl), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));

    // Single requester 2 with ideal ack loopback.
    req_valid = 4'b0100;
    set_word(2, 32'hA5A5_0002);
    ack_force_en = 1'b0;
    rstn = 1'b1;
    #1 check("t1_ready_first_idle", 64'(req_ready), 64'(4'b0100));
    exp_q.push_back({2'd2, 32'hA5A5_0002});
    @(negedge clk);
    check("t1_sync_rise", 64'(sync_ctrl), 64'(1));
    check("t1_data", 64'(data), 64'(32'hA5A5_0002));
    check("t1_src_id", 64'(src_id), 64'(2));
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_ready_busy", 64'(req_ready), 64'(0));
    req_valid = '0;
    wait_idle("t1_idle", 40, cyc);
    check("t1_busy_cycles", 64'(cyc), 64'(2 * SS + 2));
    check("t1_sync_low", 64'(sync_ctrl), 64'(0));

    // Pointer now 3: with everyone valid, requester 3 wins next.
    req_valid = '1;
    #1 check("t1_rr_ptr_3", 64'(req_ready), 64'(4'b1000));
    exp_q.push_back({2'd3, 32'hC0DE_0003});
    @(negedge clk);
    req_valid = '0;
    wait_idle("t1b_idle", 40, cyc);

    // Eight back-to-back requests from reset: strict 0,1,2,3 rotation.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    set_word(2, 32'hC0DE_0002);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back({2'(i % 4), 32'hC0DE_0000 + 32'(i % 4)});
    base = n_xfer;
    req_valid = '1;
    t = 0;
    while (n_xfer < base + 8 && t < 300) begin
      @(negedge clk);
      t++;
    end
    req_valid = '0;
    check("t2_xfer_count", 64'(n_xfer - base), 64'(8));
    wait_idle("t2_idle", 40, cyc);
    check("t2_queue_drained", 64'(exp_q.size()), 64'(0));

    // Timeout: ack held low; flag sets at the edge completing wait cycle 16.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    ack_force_en = 1'b1;
    ack_force_val = 1'b0;
    set_word(1, 32'h7777_0001);
    req_valid = 4'b0010;
    exp_q.push_back({2'd1, 32'h7777_0001});
    @(negedge clk);
    req_valid = '0;
    check("t3_timeout_w1", 64'(timeout), 64'(0));
    repeat (15) @(negedge clk);
    check("t3_timeout_w16", 64'(timeout), 64'(0));
    @(negedge clk);
    check("t3_timeout_w17", 64'(timeout), 64'(1));
    check("t3_sync_held", 64'(sync_ctrl), 64'(1));
    repeat (5) @(negedge clk);
    check("t3_still_waiting", 64'(busy), 64'(1));
    ack_force_en = 1'b0;
    wait_idle("t3_idle", 40, cyc);
    check("t3_timeout_sticky", 64'(timeout), 64'(1));

    // Reset in REQ_HI, then stale ack must block grants until it clears.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_timeout_cleared", 64'(timeout), 64'(0));
    rstn = 1'b1;
    ack_force_en = 1'b1;
    ack_force_val = 1'b0;
    set_word(0, 32'h5A5A_0000);
    req_valid = 4'b0001;
    exp_q.push_back({2'd0, 32'h5A5A_0000});
    @(negedge clk);
    req_valid = '0;
    check("t4_in_req_hi", 64'(sync_ctrl), 64'(1));
    rstn = 1'b0;
    ack_force_val = 1'b1;
    @(negedge clk);
    check("t4_rst_sync", 64'(sync_ctrl), 64'(0));
    check("t4_rst_busy", 64'(busy), 64'(0));
    check("t4_rst_data", 64'(data), 64'(0));
    rstn = 1'b1;
    repeat (SS + 1) @(negedge clk);
    req_valid = 4'b0001;
    #1 check("t4_stale_ack_block", 64'(req_ready), 64'(0));
    @(negedge clk);
    ack_force_en = 1'b0;
    exp_q.push_back({2'd0, 32'h5A5A_0000});
    @(negedge clk);
    check("t4_guard_1", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("t4_guard_2", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("t4_ready_after_ack_low", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    wait_idle("t4_idle", 40, cyc);

    // One-cycle ack glitch during REQ_HI: seen 3 flops later, no deadlock.
    ack_force_en = 1'b1;
    ack_force_val = 1'b0;
    set_word(3, 32'hDEAD_0003);
    req_valid = 4'b1000;
    exp_q.push_back({2'd3, 32'hDEAD_0003});
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    ack_force_val = 1'b1;
    @(negedge clk);
    ack_force_val = 1'b0;
    check("t5_sync_g1", 64'(sync_ctrl), 64'(1));
    @(negedge clk);
    check("t5_sync_g2", 64'(sync_ctrl), 64'(1));
    @(negedge clk);
    check("t5_sync_g3", 64'(sync_ctrl), 64'(1));
    @(negedge clk);
    check("t5_sync_drop", 64'(sync_ctrl), 64'(0));
    check("t5_busy_req_lo", 64'(busy), 64'(1));
    @(negedge clk);
    check("t5_back_idle", 64'(busy), 64'(0));
    ack_force_en = 1'b0;
    req_valid = 4'b0001;
    #1 check("t5_recover_ready", 64'(req_ready), 64'(4'b0001));
    exp_q.push_back({2'd0, 32'h5A5A_0000});
    @(negedge clk);
    req_valid = '0;
    wait_idle("t5_idle", 40, cyc);
    check("t5_sync_low", 64'(sync_ctrl), 64'(0));

    repeat (2) @(negedge clk);
    check("final_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
